// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the M-extension operations.
// Multiplies use shift-add and divides use restoring division on operand
// magnitudes, one bit per cycle. The sign is applied when the result is read out.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle
// from a combinational full product; divides are unchanged.
module ex_muldiv #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     src1_i,
  input  logic [DATA_W-1:0]     src2_i,
  input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
  input  logic                  flush_i,
  output logic                  div_hold_enable_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [REG_ADDR_W-1:0] w_reg_addr_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            op_r;
  logic [REG_ADDR_W-1:0] addr_r;
  logic                  neg_q_r;   // negate product / quotient on readout
  logic                  neg_r_r;   // negate remainder on readout
  logic [DATA_W-1:0]     mag_b_r;   // addend (multiply) or divisor magnitude
  logic [2*DATA_W-1:0]   acc_r;     // {hi, lo} product or {remainder, quotient}
  logic [CNT_W-1:0]      cnt_r;

  // Absolute value when the operand is treated as signed.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                  input logic use_sign);
    logic signed [DATA_W-1:0] n;
    n = -x;
    return (use_sign && x[DATA_W-1]) ? $unsigned(n) : $unsigned(x);
  endfunction

  // Conditional two's-complement negation, single width.
  function automatic logic [DATA_W-1:0] neg_w(input logic signed [DATA_W-1:0] x,
                                              input logic en);
    logic signed [DATA_W-1:0] n;
    n = -x;
    return en ? $unsigned(n) : $unsigned(x);
  endfunction

  // Conditional two's-complement negation, double width.
  function automatic logic [2*DATA_W-1:0] neg_2w(input logic signed [2*DATA_W-1:0] x,
                                                 input logic en);
    logic signed [2*DATA_W-1:0] n;
    n = -x;
    return en ? $unsigned(n) : $unsigned(x);
  endfunction

  logic              accept, is_div, sgn_a, sgn_b, div_zero, div_ovf, fast_path;
  logic [DATA_W-1:0] mag_a, mag_b;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
`endif

  // Decode the request presented in IDLE: signedness, special cases, magnitudes.
  always_comb begin
    is_div = op_i[2];
    if (is_div) begin
      sgn_a = !op_i[0];
      sgn_b = !op_i[0];
    end else begin
      sgn_a = (op_i[1:0] != 2'b11);
      sgn_b = !op_i[1];
    end
    accept    = (state == IDLE) && start_i && !flush_i;
    div_zero  = is_div && (src2_i == '0);
    div_ovf   = is_div && !op_i[0] && (src1_i == MOST_NEG) && (src2_i == '1);
    mag_a     = magnitude(src1_i, sgn_a);
    mag_b     = magnitude(src2_i, sgn_b);
    fast_path = div_zero || div_ovf;
`ifdef MULDIV_FAST_MUL_EN
    ext_a     = sgn_a ? {{DATA_W{src1_i[DATA_W-1]}}, src1_i} : {{DATA_W{1'b0}}, src1_i};
    ext_b     = sgn_b ? {{DATA_W{src2_i[DATA_W-1]}}, src2_i} : {{DATA_W{1'b0}}, src2_i};
    fast_prod = ext_a * ext_b;
    fast_path = fast_path || !is_div;
`endif
  end

  logic [DATA_W:0]     mul_sum, div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] mul_nxt, div_nxt;

  // One shift-add step and one restoring-division step on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + (acc_r[0] ? {1'b0, mag_b_r} : '0);
    mul_nxt   = {mul_sum, acc_r[DATA_W-1:1]};
    div_shift = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, mag_b_r};
    div_diff  = div_shift[DATA_W-1:0] - mag_b_r;
    div_nxt   = {(div_ge ? div_diff : div_shift[DATA_W-1:0]), acc_r[DATA_W-2:0], div_ge};
  end

  // Next-state logic: special cases skip CALC, flush aborts CALC only.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast_path ? DONE : CALC;
      CALC: begin
        if (flush_i)               state_nxt = IDLE;
        else if (cnt_r == CNT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture at acceptance and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= '0;
      addr_r  <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      mag_b_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r    <= op_i;
        addr_r  <= w_reg_addr_i;
        mag_b_r <= mag_b;
        cnt_r   <= '0;
        if (div_zero) begin
          acc_r   <= {src1_i, {DATA_W{1'b1}}};
          neg_q_r <= 1'b0;
          neg_r_r <= 1'b0;
        end else if (div_ovf) begin
          acc_r   <= {{DATA_W{1'b0}}, MOST_NEG};
          neg_q_r <= 1'b0;
          neg_r_r <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!is_div) begin
          acc_r   <= fast_prod;
          neg_q_r <= 1'b0;
          neg_r_r <= 1'b0;
`endif
        end else begin
          acc_r   <= {{DATA_W{1'b0}}, mag_a};
          neg_q_r <= (sgn_a & src1_i[DATA_W-1]) ^ (sgn_b & src2_i[DATA_W-1]);
          neg_r_r <= sgn_a & src1_i[DATA_W-1];
        end
      end else if (state == CALC) begin
        if (flush_i) begin
          cnt_r <= '0;
        end else begin
          acc_r <= op_r[2] ? div_nxt : mul_nxt;
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  logic [2*DATA_W-1:0] prod_fin;
  logic [DATA_W-1:0]   quo_fin, rem_fin, result_fin;

  // Result selection with sign applied, and gated outputs.
  always_comb begin
    prod_fin = neg_2w(acc_r, neg_q_r);
    quo_fin  = neg_w(acc_r[DATA_W-1:0], neg_q_r);
    rem_fin  = neg_w(acc_r[2*DATA_W-1:DATA_W], neg_r_r);
    if (!op_r[2])
      result_fin = (op_r[1:0] == 2'b00) ? prod_fin[DATA_W-1:0] : prod_fin[2*DATA_W-1:DATA_W];
    else
      result_fin = op_r[1] ? rem_fin : quo_fin;
    done_o            = !rst && (state == DONE);
    div_hold_enable_o = !rst && (accept || (state == CALC));
    result_o          = done_o ? result_fin : '0;
    w_reg_addr_o      = done_o ? addr_r : '0;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against a
// plain-arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  w_reg_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        div_hold_enable_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  w_reg_addr_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  ex_muldiv #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .w_reg_addr_i(w_reg_addr_i),
    .flush_i(flush_i), .div_hold_enable_o(div_hold_enable_o),
    .done_o(done_o), .result_o(result_o), .w_reg_addr_o(w_reg_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) r = MIN32;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Drive one request and observe it; comparisons are made by the callers.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr, output int cycles, output logic [31:0] res,
                       output logic [4:0] addr_out, output bit hold_ok, output bit pulse_ok);
    hold_ok  = 1'b1;
    res      = '0;
    addr_out = '0;
    @(negedge clk);
    op_i = op; src1_i = a; src2_i = b; w_reg_addr_i = addr; start_i = 1'b1;
    #1 if (div_hold_enable_o !== 1'b1) hold_ok = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); src1_i = $urandom; src2_i = $urandom; w_reg_addr_i = 5'($urandom);
    cycles = 1;
    while (done_o !== 1'b1 && cycles < 100) begin
      if (div_hold_enable_o !== 1'b1) hold_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    if (done_o === 1'b1) begin
      res = result_o;
      addr_out = w_reg_addr_o;
      if (div_hold_enable_o !== 1'b0) hold_ok = 1'b0;
    end else begin
      cycles = -1;
    end
    @(posedge clk); #1;
    pulse_ok = (done_o === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; op_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7;
    w_reg_addr_i = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (div_hold_enable_o !== 1'b0) $display("FAIL rst_hold: got %b want 0", div_hold_enable_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'd0) $display("FAIL rst_result: got %h want 0", result_o); else pass_cnt++;
    total_cnt++; if (w_reg_addr_o !== 5'd0) $display("FAIL rst_addr: got %h want 0", w_reg_addr_o); else pass_cnt++;
    start_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (div_hold_enable_o !== 1'b0) $display("FAIL post_rst_hold: got %b want 0", div_hold_enable_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL post_rst_done: got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'd0) $display("FAIL post_rst_result: got %h want 0", result_o); else pass_cnt++;
    total_cnt++; if (w_reg_addr_o !== 5'd0) $display("FAIL post_rst_addr: got %h want 0", w_reg_addr_o); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [14];
    logic [31:0] t_a [14];
    logic [31:0] t_b [14];
    logic [31:0] t_exp [14];
    int          cyc;
    logic [31:0] res;
    logic [4:0]  ad;
    bit          hok, pok;
    t_op  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    t_a   = '{32'd7, MIN32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
              32'd100, 32'd100, 32'd5, 32'd5, MIN32, MIN32, 32'd5, 32'h1234_5678};
    t_b   = '{32'hFFFF_FFFD, MIN32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_exp = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MIN32, 32'd0,
              32'hFFFF_FFFF, 32'h1234_5678};
    for (int i = 0; i < 14; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), cyc, res, ad, hok, pok);
      total_cnt++; if (res !== t_exp[i]) $display("FAIL dir%0d_result: got %h want %h", i, res, t_exp[i]); else pass_cnt++;
      total_cnt++; if (cyc != exp_latency(t_op[i], t_a[i], t_b[i])) $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, exp_latency(t_op[i], t_a[i], t_b[i])); else pass_cnt++;
      total_cnt++; if (ad !== 5'(i + 1)) $display("FAIL dir%0d_addr: got %h want %h", i, ad, 5'(i + 1)); else pass_cnt++;
      total_cnt++; if (!hok) $display("FAIL dir%0d_hold: got bad want ok", i); else pass_cnt++;
      total_cnt++; if (!pok) $display("FAIL dir%0d_pulse: got long want one cycle", i); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, want;
    logic [4:0]  addr, ad;
    int          cyc;
    bit          hok, pok;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      addr = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MIN32; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 5);
        default: ;
      endcase
      want = ref_result(op, a, b);
      do_op(op, a, b, addr, cyc, res, ad, hok, pok);
      total_cnt++; if (res !== want) $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, want); else pass_cnt++;
      total_cnt++; if (cyc != exp_latency(op, a, b)) $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, exp_latency(op, a, b)); else pass_cnt++;
      total_cnt++; if (ad !== addr) $display("FAIL rnd%0d_addr: got %h want %h", i, ad, addr); else pass_cnt++;
      total_cnt++; if (!(hok && pok)) $display("FAIL rnd%0d_hold_pulse: got hold=%0d pulse=%0d want 1 1", i, hok, pok); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    int          seen;
    int          cyc;
    logic [31:0] a, b, res;
    logic [4:0]  ad;
    bit          hok, pok;
    // flush during CALC
    seen = 0;
    @(negedge clk);
    op_i = 3'd4; src1_i = $urandom; src2_i = 32'($urandom_range(3, 1000)); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    total_cnt++; if (div_hold_enable_o !== 1'b0) $display("FAIL flush_calc_hold: got %b want 0", div_hold_enable_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0 || seen != 0) $display("FAIL flush_calc_done: got %b/%0d want 0/0", done_o, seen); else pass_cnt++;
    a = $urandom; b = 32'($urandom_range(1, 50000));
    do_op(3'd4, a, b, 5'd9, cyc, res, ad, hok, pok);
    total_cnt++; if (res !== ref_result(3'd4, a, b)) $display("FAIL flush_restart_result: got %h want %h", res, ref_result(3'd4, a, b)); else pass_cnt++;
    total_cnt++; if (cyc != 33) $display("FAIL flush_restart_latency: got %0d want 33", cyc); else pass_cnt++;
    // flush together with start in IDLE
    seen = 0;
    @(negedge clk);
    op_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7; start_i = 1'b1; flush_i = 1'b1;
    #1;
    total_cnt++; if (div_hold_enable_o !== 1'b0) $display("FAIL flush_start_hold: got %b want 0", div_hold_enable_o); else pass_cnt++;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1 || div_hold_enable_o === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total_cnt++; if (seen != 0) $display("FAIL flush_start_idle: got %0d active cycles want 0", seen); else pass_cnt++;
    // flush while DONE still delivers the result
    @(negedge clk);
    op_i = 3'd5; src1_i = 32'd5; src2_i = 32'd0; w_reg_addr_i = 5'd17; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    total_cnt++; if (done_o !== 1'b1) $display("FAIL flush_done_pulse: got %b want 1", done_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'hFFFF_FFFF) $display("FAIL flush_done_result: got %h want ffffffff", result_o); else pass_cnt++;
    total_cnt++; if (w_reg_addr_o !== 5'd17) $display("FAIL flush_done_addr: got %h want 11", w_reg_addr_o); else pass_cnt++;
    @(posedge clk); #1;
    flush_i = 1'b0;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL flush_done_after: got %b want 0", done_o); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    op_i = 3'd5; src1_i = $urandom; src2_i = 32'($urandom_range(1, 9999));
    w_reg_addr_i = 5'd21; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (div_hold_enable_o !== 1'b0) $display("FAIL rst_mid_hold: got %b want 0", div_hold_enable_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'd0 || w_reg_addr_o !== 5'd0) $display("FAIL rst_mid_data: got %h/%h want 0/0", result_o, w_reg_addr_o); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1 || div_hold_enable_o === 1'b1) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL rst_mid_abandon: got %0d active cycles want 0", seen); else pass_cnt++;
  endtask

  task automatic test_start_in_calc();
    int          dones;
    logic [31:0] res;
    dones = 0;
    res = '0;
    @(negedge clk);
    op_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7; w_reg_addr_i = 5'd4; start_i = 1'b1;
    @(posedge clk); #1;
    op_i = 3'd3; src1_i = 32'hFFFF_FFFF; src2_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) start_i = 1'b0;
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        dones++;
        res = result_o;
      end
    end
    total_cnt++; if (dones != 1) $display("FAIL calc_start_dones: got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (res !== 32'd14) $display("FAIL calc_start_result: got %h want 0000000e", res); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_rst_mid();
    test_start_in_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width (even, >=8).
REQ-002 Parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request; sampled only in IDLE.
REQ-006 op_i  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 src1_i  input  DATA_W  rs1 operand (multiplicand/dividend).
REQ-008 src2_i  input  DATA_W  rs2 operand (multiplier/divisor).
REQ-009 w_reg_addr_i  input  REG_ADDR_W  destination register.
REQ-010 flush_i  input  1  abort the in-flight operation (taken jump/exception).
REQ-011 div_hold_enable_o  output  1  pipeline hold request.
REQ-012 done_o  output  1  one-cycle pulse; result valid.
REQ-013 result_o  output  DATA_W  result, valid only while done_o=1, else 0.
REQ-014 w_reg_addr_o  output  REG_ADDR_W  latched destination, valid with done_o, else 0.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE->CALC on start_i (normal case); CALC->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-016 On acceptance, op_i, src1_i, src2_i, w_reg_addr_i are registered; later input changes have no effect.
REQ-017 Multiply: iterative shift-add on operand magnitudes, one bit per cycle, DATA_W cycles in CALC, 2*DATA_W-bit product.
REQ-018 Divide: restoring, one quotient bit per cycle, DATA_W cycles in CALC.
REQ-019 Signedness: MUL/MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; sign applied after magnitude computation.
REQ-020 MUL returns low DATA_W product bits; MULH/MULHSU/MULHU return high DATA_W bits.
REQ-021 REM sign follows dividend; DIV truncates toward zero.
REQ-022 Divisor zero: IDLE->DONE directly; quotient all-ones, remainder = dividend (both signed and unsigned).
REQ-023 Signed overflow (dividend = most-negative, divisor = -1): IDLE->DONE directly; quotient = most-negative, remainder 0.
REQ-024 Latency: start accepted at cycle N; done_o at N+DATA_W+1 normally, N+1 for REQ-022/023 cases.
REQ-025 div_hold_enable_o = (state==IDLE && start_i && !flush_i) || state==CALC; low in DONE, so the pipeline advances on the done_o cycle.
REQ-026 start_i in CALC or DONE is ignored; no queueing.
REQ-027 flush_i in CALC: next state IDLE, no done_o, iteration state discarded.
REQ-028 flush_i in DONE: done_o still pulses (result already committed to writeback).
REQ-029 flush_i and start_i together in IDLE: flush wins, nothing accepted.

Reset
REQ-030 rst (synchronous) forces IDLE and clears all operand, iteration and counter registers.
REQ-031 During and after reset: div_hold_enable_o=0, done_o=0, result_o=0, w_reg_addr_o=0.
REQ-032 rst mid-operation abandons the operation with no done_o.

Configuration
REQ-033 Macro MULDIV_FAST_MUL_EN: when defined, multiply ops compute the full product combinationally at acceptance and go IDLE->DONE (latency 1); divide unchanged.
REQ-034 When MULDIV_FAST_MUL_EN is undefined, multiplies use the iterative path of REQ-017 (latency DATA_W+1); results are identical in both builds.

Verification (DATA_W=32)
REQ-035 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done_o 33 cycles after start (1 with MULDIV_FAST_MUL_EN), hold high until done cycle.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; each done at +33.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each done at +1.
REQ-039 DIV started, flush_i at CALC cycle 10 -> no done_o, hold low next cycle; new start next cycle completes correctly.
REQ-040 rst asserted at CALC cycle 5 -> all outputs 0 next cycle, no done_o; start_i during CALC ignored (single done_o only).
